cam_timing_gen_module: RTL and testbench

CAM_TIMING_GEN_MODULE -- requirements
Module: cam_timing_gen_module

---
 rtl/cam_timing_gen_module.sv | 116 +++++++++++
 tb/tb_cam_timing_gen_module.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cam_timing_gen_module.sv
// Camera sensor timing generator: VSYNC/HREF framing with selectable test-pattern pixel data.
// Outputs are registered from the next-cycle counters so they line up with (h_cnt, v_cnt).
module cam_timing_gen_module #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start_Sig,
  input  logic [1:0] Mode,
  output logic       Pin_VSYNC,
  output logic       Pin_HREF,
  output logic [7:0] Pin_DATA,
  output logic       Frame_Done,
  output logic       Busy
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW      = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;
  localparam int V_ACT0  = V_SYNC + V_BACK;
  localparam int V_ACT1  = V_ACT0 + V_ACTIVE;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   h_cnt, h_nxt;
  logic [VW-1:0]   v_cnt, v_nxt;
  logic [1:0]      mode_r, mode_nxt;
  logic            vsync_p0, href_p0, done_p0, busy_p0;
  logic [7:0]      data_p0;

  function automatic logic [7:0] pixel(input logic [1:0] m, input int x, input int y);
    logic [31:0] xs, ys;
    xs = x;
    ys = y;
    case (m)
      2'd0:    pixel = xs[7:0];
      2'd1:    pixel = ys[7:0];
      2'd2:    pixel = 8'h80;
      default: pixel = (xs[3] ^ ys[3]) ? 8'hFF : 8'h00;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    mode_nxt  = mode_r;
    case (state)
      IDLE: begin
        if (Start_Sig) begin
          state_nxt = RUN;
          h_nxt     = '0;
          v_nxt     = '0;
          mode_nxt  = Mode;
        end
      end
      default: begin
        if (h_cnt == HW'(H_TOTAL - 1)) begin
          h_nxt = '0;
          if (v_cnt == VW'(V_TOTAL - 1)) begin
            v_nxt = '0;
            // Frame boundary is the only place a stop or a new Mode takes effect
            if (Start_Sig) mode_nxt = Mode;
            else           state_nxt = IDLE;
          end else begin
            v_nxt = v_cnt + 1'b1;
          end
        end else begin
          h_nxt = h_cnt + 1'b1;
        end
      end
    endcase
  end

  // Stage p0: decode the counters the registers are about to hold
  always_comb begin
    busy_p0  = (state_nxt == RUN);
    vsync_p0 = busy_p0 && (int'(v_nxt) < V_SYNC);
    href_p0  = busy_p0 && (int'(v_nxt) >= V_ACT0) && (int'(v_nxt) < V_ACT1)
               && (int'(h_nxt) < H_ACTIVE);
    data_p0  = href_p0 ? pixel(mode_nxt, int'(h_nxt), int'(v_nxt) - V_ACT0) : 8'h00;
    done_p0  = busy_p0 && (h_nxt == HW'(H_TOTAL - 1)) && (v_nxt == VW'(V_TOTAL - 1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      mode_r     <= 2'd0;
      Pin_VSYNC  <= 1'b0;
      Pin_HREF   <= 1'b0;
      Pin_DATA   <= 8'h00;
      Frame_Done <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      mode_r     <= mode_nxt;
      Pin_VSYNC  <= vsync_p0;
      Pin_HREF   <= href_p0;
      Pin_DATA   <= data_p0;
      Frame_Done <= done_p0;
      Busy       <= busy_p0;
    end
  end

endmodule

// File: tb/tb_cam_timing_gen_module.sv
// Bench for cam_timing_gen_module: small-frame vector table plus a checkerboard frame
// on a second instance sized 16x16 active.
module tb_cam_timing_gen_module;

  logic       clk;
  logic       rst, start;
  logic [1:0] mode;
  logic       vsync, href, done, busy;
  logic [7:0] data;
  logic       rst_c, start_c;
  logic [1:0] mode_c;
  logic       vsync_c, href_c, done_c, busy_c;
  logic [7:0] data_c;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  cam_timing_gen_module #(
    .H_ACTIVE(4), .H_BLANK(2), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1)
  ) u_dut (
    .CLK(clk), .RST(rst), .Start_Sig(start), .Mode(mode),
    .Pin_VSYNC(vsync), .Pin_HREF(href), .Pin_DATA(data),
    .Frame_Done(done), .Busy(busy)
  );

  cam_timing_gen_module #(
    .H_ACTIVE(16), .H_BLANK(2), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(16), .V_FRONT(1)
  ) u_chk (
    .CLK(clk), .RST(rst_c), .Start_Sig(start_c), .Mode(mode_c),
    .Pin_VSYNC(vsync_c), .Pin_HREF(href_c), .Pin_DATA(data_c),
    .Frame_Done(done_c), .Busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {vsync, href, data, done, busy} for frame cycle t of a running frame
  function automatic logic [11:0] model(int t, int m, int ha, int hb, int vs, int vb,
                                        int va, int vf);
    int ht, vt, line, x, y;
    logic v_s, hr, dn;
    logic [7:0] d;
    ht   = ha + hb;
    vt   = vs + vb + va + vf;
    line = t / ht;
    x    = t % ht;
    y    = line - vs - vb;
    v_s  = (line < vs);
    hr   = (line >= vs + vb) && (line < vs + vb + va) && (x < ha);
    d    = 8'h00;
    if (hr) begin
      case (m)
        0:       d = 8'(x);
        1:       d = 8'(y);
        2:       d = 8'h80;
        default: d = (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
      endcase
    end
    dn = (t == ht * vt - 1);
    return {v_s, hr, d, dn, 1'b1};
  endfunction

  function automatic logic [11:0] small_exp(int t, int m);
    return model(t, m, 4, 2, 1, 1, 3, 1);
  endfunction

  function automatic void add(logic r, logic s, logic [1:0] m, logic [11:0] e, string n);
    vec_t v;
    v.rst = r; v.start = s; v.mode = m; v.exp = e; v.name = n;
    tbl.push_back(v);
  endfunction

  task automatic check(input logic [11:0] act, input logic [11:0] exp, input string n,
                       input int idx);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got {vs,href,data,done,busy}=%b_%b_%h_%b_%b want %b_%b_%h_%b_%b",
               n, idx, act[11], act[10], act[9:2], act[1], act[0],
               exp[11], exp[10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0;
    rst_c = 1'b1; start_c = 1'b0; mode_c = 2'd0;

    // Reset overrides Start_Sig, then idle until a start edge
    add(1, 1, 3, 12'h000, "reset_ovr");
    add(1, 1, 3, 12'h000, "reset_ovr");
    add(0, 0, 0, 12'h000, "idle_after_rst");
    add(0, 0, 0, 12'h000, "idle_after_rst");

    // Single frame from a one-cycle start pulse
    add(0, 1, 0, small_exp(0, 0), "single");
    for (int k = 1; k < 36; k++) add(0, 0, 0, small_exp(k, 0), "single");
    for (int k = 0; k < 3; k++)  add(0, 0, 0, 12'h000, "single_idle");

    // Continuous frames, start held through the second boundary only
    for (int k = 0; k < 72; k++) add(0, 1, 0, small_exp(k % 36, 0), "contin");
    add(0, 0, 0, 12'h000, "contin_stop");

    // Mode latch, then stop requested early in the second frame
    for (int k = 0; k < 72; k++) begin
      logic       s;
      logic [1:0] m;
      s = (k < 41);
      m = (k < 10) ? 2'd1 : (k < 50) ? 2'd2 : 2'd3;
      add(0, s, m, small_exp(k % 36, (k < 36) ? 1 : 2), "modelatch");
    end
    add(0, 0, 3, 12'h000, "stop_idle");
    add(0, 0, 3, 12'h000, "stop_idle");

    // Reset mid-frame with start held, then restart
    for (int k = 0; k < 15; k++) add(0, 1, 0, small_exp(k, 0), "midrst");
    add(1, 1, 0, 12'h000, "midrst_abort");
    add(0, 1, 0, small_exp(0, 0), "midrst_restart");
    for (int k = 1; k < 5; k++) add(0, 0, 0, small_exp(k, 0), "midrst_restart");
    add(1, 0, 0, 12'h000, "final_rst");
    add(0, 0, 0, 12'h000, "final_idle");

    foreach (tbl[i]) begin
      rst   = tbl[i].rst;
      start = tbl[i].start;
      mode  = tbl[i].mode;
      @(posedge clk);
      #1;
      check({vsync, href, data, done, busy}, tbl[i].exp, tbl[i].name, i);
    end

    // Checkerboard frame on the 16x16 instance; Mode input changes mid-frame
    rst_c = 1'b0; start_c = 1'b1; mode_c = 2'd3;
    @(posedge clk);
    #1;
    check({vsync_c, href_c, data_c, done_c, busy_c},
          model(0, 3, 16, 2, 1, 1, 16, 1), "checker", 0);
    start_c = 1'b0;
    for (int t = 1; t < 18 * 19; t++) begin
      if (t == 100) mode_c = 2'd0;
      @(posedge clk);
      #1;
      check({vsync_c, href_c, data_c, done_c, busy_c},
            model(t, 3, 16, 2, 1, 1, 16, 1), "checker", t);
    end
    @(posedge clk);
    #1;
    check({vsync_c, href_c, data_c, done_c, busy_c}, 12'h000, "checker_idle", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
